l2_port_arbiter: RTL and testbench

// - Shares the single L2 port between NUM_REQ L1 cache controllers (e.g. I-side, D-side).
// - Round-robin arbitration; each grant is locked for the whole miss:

---
 rtl/l2_port_arbiter_pkg.sv | 27 ++
 rtl/l2_port_arbiter_if.sv | 30 +++
 rtl/l2_port_arbiter_rr_picker.sv | 34 +++
 rtl/l2_port_arbiter.sv | 122 ++++++++++++
 tb/tb_l2_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared definitions for the L2 port arbiter: FSM state encoding, address
// geometry and a width helper for counters and indices.
package l2_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int L2_ADDR_W = 32;
  localparam int TAG_W     = 21;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [L2_ADDR_W-1:0] addr);
    return addr[L2_ADDR_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle between the L1 cache controllers, the arbiter and the single L2 port.
// The arbiter uses the slave view; the controllers/L2 side use the master view.
interface l2_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) ();

  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] rd_addr;
  logic [NUM_REQ*ADDR_W-1:0] wb_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      l2_read;
  logic                      l2_write;
  logic [ADDR_W-1:0]         l2_addr;
  logic                      l2_ack;

  modport slave (
    input  req_rd, req_wr, rd_addr, wb_addr, l2_ack,
    output gnt, done, err, l2_read, l2_write, l2_addr
  );

  modport master (
    output req_rd, req_wr, rd_addr, wb_addr, l2_ack,
    input  gnt, done, err, l2_read, l2_write, l2_addr
  );

endinterface

// File: rtl/l2_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping, returned as one-hot, as an index and as an any-request flag.
module l2_port_arbiter_rr_picker
  import l2_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    j      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(i_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!o_any && i_req[IDX_W'(j)]) begin
        o_any               = 1'b1;
        o_idx               = IDX_W'(j);
        o_pick[IDX_W'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin owner of the single L2 port: locks a grant for a whole miss,
// sequencing an optional write-back then the refill read, each phase time-limited.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = L2_ADDR_W,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  l2_port_arbiter_if.slave bus
);

  localparam int IDX_W   = clog2_min1(NUM_REQ);
  localparam int TMO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CNT_W   = clog2_min1(TMO_LIM + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [ADDR_W-1:0]  r_wb_addr;
  logic               r_pend_rd;
  logic               r_err;
  logic [CNT_W-1:0]   r_tmo_cnt;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_pick;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_in_phase;
  logic               w_tmo_hit;
  logic [NUM_REQ-1:0] w_sel_oh;

  assign w_req      = bus.req_rd | bus.req_wr;
  assign w_in_phase = (r_state == ST_WB) || (r_state == ST_RD);
  assign w_tmo_hit  = (TIMEOUT > 0) && (r_tmo_cnt == CNT_W'(TMO_LIM));
  assign w_sel_oh   = NUM_REQ'(1) << r_sel;

  l2_port_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req  (w_req),
    .i_ptr  (r_rr_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus output decode; outputs depend only on registered state/sel.
  always_comb begin
    w_state_nxt  = r_state;
    bus.gnt      = '0;
    bus.done     = '0;
    bus.err      = '0;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
    bus.l2_addr  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = (|(bus.req_wr & w_pick)) ? ST_WB : ST_RD;
      end
      ST_WB: begin
        bus.gnt      = w_sel_oh;
        bus.l2_write = 1'b1;
        bus.l2_addr  = r_wb_addr;
        if (bus.l2_ack)     w_state_nxt = r_pend_rd ? ST_RD : ST_DONE;
        else if (w_tmo_hit) w_state_nxt = ST_DONE;
      end
      ST_RD: begin
        bus.gnt     = w_sel_oh;
        bus.l2_read = 1'b1;
        bus.l2_addr = r_rd_addr;
        if (bus.l2_ack || w_tmo_hit) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.gnt     = w_sel_oh;
        bus.done    = w_sel_oh;
        bus.err     = r_err ? w_sel_oh : '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: these are plain registers, not a memory, so all of them take the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel     <= '0;
      r_rr_ptr  <= '0;
      r_rd_addr <= '0;
      r_wb_addr <= '0;
      r_pend_rd <= 1'b0;
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_sel     <= w_idx;
        r_rd_addr <= bus.rd_addr[w_idx*ADDR_W +: ADDR_W];
        r_wb_addr <= bus.wb_addr[w_idx*ADDR_W +: ADDR_W];
        r_pend_rd <= |(bus.req_rd & w_pick);
        r_err     <= 1'b0;
      end
      if (w_in_phase && !bus.l2_ack && w_tmo_hit) r_err <= 1'b1;
      if (r_state == ST_DONE)
        r_rr_ptr <= (r_sel == IDX_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
      // Counter restarts on every state change, so each phase gets its own budget.
      if (w_state_nxt != r_state) r_tmo_cnt <= '0;
      else if (w_in_phase)        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: expected L2 phases and done/err pulses
// are queued as stimulus is driven and popped as the DUT shows each event.
module tb_l2_port_arbiter;

  typedef enum int {EV_NONE, EV_WR, EV_RD, EV_DONE} ev_e;
  typedef struct {
    ev_e         kind;
    int          idx;
    logic [31:0] addr;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   resp_en = 1'b0;
  bit   resp_ack = 1'b0;
  bit   force_ack = 1'b1;
  int   ack_delay = 0;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  int   rd_cycles = 0;
  int   wr_cycles = 0;
  bit   p_rd = 1'b0;
  bit   p_wr = 1'b0;
  logic [1:0] p_cur = 2'b00;
  int   rcnt = 0;

  l2_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32)) bus ();

  l2_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .TIMEOUT(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.l2_ack = resp_en ? resp_ack : force_ack;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input ev_e kind, input int idx, input logic [31:0] addr, input bit err);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.addr = addr;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic ev_check(input ev_e kind);
    exp_t e;
    logic [1:0] oh;
    check("rw_excl", 64'(bus.l2_read & bus.l2_write), 64'd0);
    if (sb.size() == 0) begin
      check("unexpected_ev", 64'(kind), 64'(EV_NONE));
      return;
    end
    e  = sb.pop_front();
    oh = 2'b01 << e.idx;
    check("ev_kind", 64'(kind), 64'(e.kind));
    check("gnt", 64'(bus.gnt), 64'(oh));
    if (kind == EV_DONE) begin
      check("done", 64'(bus.done), 64'(oh));
      check("err", 64'(bus.err), e.err ? 64'(oh) : 64'd0);
      check("strobes_in_done", 64'({bus.l2_read, bus.l2_write}), 64'd0);
    end else begin
      check("l2_addr", 64'(bus.l2_addr), 64'(e.addr));
    end
  endtask

  // L2 model: acks the ack_delay-th cycle of each phase; 0 means never.
  always @(negedge clk) begin
    logic [1:0] cur;
    cur = {bus.l2_write, bus.l2_read};
    if (cur != p_cur) rcnt = 0;
    if (cur != 2'b00) rcnt++;
    resp_ack = (cur != 2'b00) && (ack_delay != 0) && (rcnt == ack_delay);
    p_cur = cur;
  end

  // Monitor: every phase start and every done cycle is scored.
  always @(negedge clk) begin
    if (bus.l2_write && !p_wr) begin
      ev_check(EV_WR);
      wr_cycles = 0;
    end
    if (bus.l2_read && !p_rd) begin
      ev_check(EV_RD);
      rd_cycles = 0;
    end
    if (bus.l2_write) wr_cycles++;
    if (bus.l2_read)  rd_cycles++;
    if (|bus.done) ev_check(EV_DONE);
    p_wr = bus.l2_write;
    p_rd = bus.l2_read;
  end

  task automatic wait_done(input int idx, input bit clr);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.done[idx]) seen = 1'b1;
    end
    check($sformatf("wait_done%0d", idx), 64'(seen), 64'd1);
    if (clr) begin
      bus.req_rd[idx] = 1'b0;
      bus.req_wr[idx] = 1'b0;
    end
  endtask

  task automatic wait_write();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.l2_write) seen = 1'b1;
    end
    check("wait_write", 64'(seen), 64'd1);
  endtask

  task automatic settle_drain(input string tag);
    repeat (2) @(negedge clk);
    #1;
    check(tag, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  function automatic logic [39:0] all_outs();
    return {bus.gnt, bus.done, bus.err, bus.l2_read, bus.l2_write, bus.l2_addr};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_rd  = '0;
    bus.req_wr  = '0;
    bus.rd_addr = '0;
    bus.wb_addr = '0;

    // Reset held with random inputs and ack high: everything stays quiet.
    repeat (5) begin
      @(negedge clk);
      check("rst_outs", 64'(all_outs()), 64'd0);
      bus.req_rd  = 2'($urandom);
      bus.req_wr  = 2'($urandom);
      bus.rd_addr = {$urandom, $urandom};
      bus.wb_addr = {$urandom, $urandom};
    end
    bus.req_rd = '0;
    bus.req_wr = '0;
    force_ack  = 1'b0;
    reset      = 1'b1;
    resp_en    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_rst", 64'(all_outs()), 64'd0);
    end

    // Clean miss on requester 0; address change after grant is ignored.
    ack_delay = 8;
    push(EV_RD, 0, 32'h1000_1fff, 1'b0);
    push(EV_DONE, 0, 32'h0, 1'b0);
    bus.rd_addr[31:0] = 32'h1000_1fff;
    bus.req_rd = 2'b01;
    @(negedge clk);
    check("miss_lat_read", 64'(bus.l2_read), 64'd1);
    check("miss_lat_gnt", 64'(bus.gnt), 64'd1);
    bus.rd_addr[31:0] = 32'hdead_beef;
    wait_done(0, 1'b1);
    settle_drain("drain_clean");
    check("clean_rd_len", 64'(rd_cycles), 64'd8);

    // Dirty miss on requester 1; requests dropped mid-write-back still finish.
    ack_delay = 5;
    push(EV_WR, 1, 32'h2000_2000, 1'b0);
    push(EV_RD, 1, 32'h1000_1000, 1'b0);
    push(EV_DONE, 1, 32'h0, 1'b0);
    bus.wb_addr[63:32] = 32'h2000_2000;
    bus.rd_addr[63:32] = 32'h1000_1000;
    bus.req_wr = 2'b10;
    bus.req_rd = 2'b10;
    wait_write();
    bus.req_rd = 2'b00;
    bus.req_wr = 2'b00;
    bus.wb_addr[63:32] = 32'h5555_5555;
    bus.rd_addr[63:32] = 32'haaaa_aaaa;
    wait_done(1, 1'b1);
    settle_drain("drain_dirty");
    check("dirty_wr_len", 64'(wr_cycles), 64'd5);
    check("dirty_rd_len", 64'(rd_cycles), 64'd5);

    // Contention with pointer at 0, both held across grants: 0,1,0,1.
    ack_delay = 3;
    bus.rd_addr = {32'h2000_0080, 32'h1000_0040};
    for (int k = 0; k < 4; k++) begin
      push(EV_RD, k % 2, (k % 2 == 0) ? 32'h1000_0040 : 32'h2000_0080, 1'b0);
      push(EV_DONE, k % 2, 32'h0, 1'b0);
    end
    bus.req_rd = 2'b11;
    wait_done(0, 1'b0);
    wait_done(1, 1'b0);
    wait_done(0, 1'b1);
    wait_done(1, 1'b1);
    settle_drain("drain_contend0");

    // Read phase timeout: 16 cycles in RD then done with err.
    ack_delay = 0;
    push(EV_RD, 0, 32'h1000_0040, 1'b0);
    push(EV_DONE, 0, 32'h0, 1'b1);
    bus.req_rd = 2'b01;
    wait_done(0, 1'b1);
    settle_drain("drain_tmo_rd");
    check("tmo_rd_len", 64'(rd_cycles), 64'd16);

    // Ack on the limit cycle wins: no err.
    ack_delay = 16;
    push(EV_RD, 0, 32'h1000_0040, 1'b0);
    push(EV_DONE, 0, 32'h0, 1'b0);
    bus.req_rd = 2'b01;
    wait_done(0, 1'b1);
    settle_drain("drain_ack_limit");
    check("ack_limit_len", 64'(rd_cycles), 64'd16);

    // Contention with pointer at 1: requester 1 goes first.
    ack_delay = 2;
    push(EV_RD, 1, 32'h2000_0080, 1'b0);
    push(EV_DONE, 1, 32'h0, 1'b0);
    push(EV_RD, 0, 32'h1000_0040, 1'b0);
    push(EV_DONE, 0, 32'h0, 1'b0);
    bus.req_rd = 2'b11;
    wait_done(1, 1'b1);
    wait_done(0, 1'b1);
    settle_drain("drain_contend1");

    // Write-back timeout skips the pending read.
    ack_delay = 0;
    push(EV_WR, 1, 32'h3000_3000, 1'b0);
    push(EV_DONE, 1, 32'h0, 1'b1);
    bus.wb_addr[63:32] = 32'h3000_3000;
    bus.req_wr = 2'b10;
    bus.req_rd = 2'b10;
    wait_done(1, 1'b1);
    settle_drain("drain_tmo_wb");
    check("tmo_wb_len", 64'(wr_cycles), 64'd16);

    // Asynchronous reset mid write-back, then a stray ack in IDLE.
    push(EV_WR, 1, 32'h3000_3000, 1'b0);
    bus.req_wr = 2'b10;
    bus.req_rd = 2'b10;
    wait_write();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", 64'(all_outs()), 64'd0);
    bus.req_rd = '0;
    bus.req_wr = '0;
    @(negedge clk);
    check("rst_hold", 64'(all_outs()), 64'd0);
    reset   = 1'b1;
    resp_en = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stray_ack", 64'(all_outs()), 64'd0);
    end
    settle_drain("drain_stray");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
